// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared opcodes, mul/div FSM states and width default for alu_md_unit
package alu_pkg;

    localparam int ALU_WIDTH = 32;

    // Operation codes, shared with the ALU controller; 14-15 fall through as NOP
    typedef enum logic [3:0] {
        OP_NOP  = 4'd0,
        OP_XOR  = 4'd1,
        OP_OR   = 4'd2,
        OP_AND  = 4'd3,
        OP_NOR  = 4'd4,
        OP_SLL  = 4'd5,
        OP_SRL  = 4'd6,
        OP_SLT  = 4'd7,
        OP_ADD  = 4'd8,
        OP_ADDU = 4'd9,
        OP_SUB  = 4'd10,
        OP_SUBU = 4'd11,
        OP_MULT = 4'd12,
        OP_DIV  = 4'd13
    } alu_op_t;

    typedef enum logic [1:0] {
        MD_IDLE = 2'd0,
        MD_MUL  = 2'd1,
        MD_DIV  = 2'd2,
        MD_DONE = 2'd3
    } md_state_t;

endpackage

// File: rtl/alu_md_iter.sv
// rtl/alu_md_iter.sv - radix-2 sign-magnitude multiply / restoring divide datapath
module alu_md_iter
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             step,
    input  logic             div_mode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             last,
    output logic [WIDTH-1:0] hi_res,
    output logic [WIDTH-1:0] lo_res
);
    localparam int CW = $clog2(WIDTH);

    // acc holds the high product half / partial remainder; sh holds the multiplier / dividend-quotient
    logic [WIDTH-1:0]   acc_q, acc_d;
    logic [WIDTH-1:0]   sh_q, sh_d;
    logic [WIDTH-1:0]   opnd_q;
    logic [CW-1:0]      cnt_q;
    logic               neg_q, neg_rem_q;
    logic [WIDTH:0]     sum;
    logic [WIDTH:0]     trial;
    logic [2*WIDTH-1:0] prod;

    // One iteration step; the final results are taken from the next-state values so hi/lo load on the last step edge
    always_comb begin
        sum   = {1'b0, acc_q} + {1'b0, opnd_q};
        trial = {acc_q, sh_q[WIDTH-1]};
        acc_d = acc_q;
        sh_d  = sh_q;
        if (div_mode) begin
            if (trial >= {1'b0, opnd_q}) begin
                acc_d = trial[WIDTH-1:0] - opnd_q;
                sh_d  = {sh_q[WIDTH-2:0], 1'b1};
            end else begin
                acc_d = trial[WIDTH-1:0];
                sh_d  = {sh_q[WIDTH-2:0], 1'b0};
            end
        end else if (sh_q[0]) begin
            {acc_d, sh_d} = {sum, sh_q[WIDTH-1:1]};
        end else begin
            {acc_d, sh_d} = {1'b0, acc_q, sh_q[WIDTH-1:1]};
        end
        prod   = neg_q ? -{acc_d, sh_d} : {acc_d, sh_d};
        hi_res = div_mode ? (neg_rem_q ? -acc_d : acc_d) : prod[2*WIDTH-1:WIDTH];
        lo_res = div_mode ? (neg_q ? -sh_d : sh_d) : prod[WIDTH-1:0];
    end

    assign last = step && (cnt_q == CW'(WIDTH - 1));

    // Latch operand magnitudes and result signs at start, then advance one bit per cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q     <= '0;
            sh_q      <= '0;
            opnd_q    <= '0;
            cnt_q     <= '0;
            neg_q     <= 1'b0;
            neg_rem_q <= 1'b0;
        end else if (load) begin
            acc_q     <= '0;
            sh_q      <= a[WIDTH-1] ? -a : a;
            opnd_q    <= b[WIDTH-1] ? -b : b;
            cnt_q     <= '0;
            neg_q     <= a[WIDTH-1] ^ b[WIDTH-1];
            neg_rem_q <= a[WIDTH-1];
        end else if (step) begin
            acc_q <= acc_d;
            sh_q  <= sh_d;
            cnt_q <= cnt_q + 1'b1;
        end
    end

endmodule

// File: rtl/alu_md_unit.sv
// rtl/alu_md_unit.sv - combinational ALU plus HI/LO mul/div unit; ALU_MD_FAST_MULT_EN selects single-cycle MULT
module alu_md_unit
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [3:0]       alu_operation,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             start,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             overflow,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy,
    output logic             done
);
    alu_op_t          op;
    md_state_t        state_q;
    logic [WIDTH-1:0] hi_q, lo_q;
    logic             busy_q, done_q;
    logic [WIDTH-1:0] sum, diff;
    logic             go_mul, go_div, div_zero, iter_load, iter_last;
    logic [WIDTH-1:0] iter_hi, iter_lo;

    assign op = alu_op_t'(alu_operation);

    // Single-cycle ALU, independent of the mul/div state
    always_comb begin
        sum      = a + b;
        diff     = a - b;
        result   = '0;
        overflow = 1'b0;
        case (op)
            OP_XOR:  result = a ^ b;
            OP_OR:   result = a | b;
            OP_AND:  result = a & b;
            OP_NOR:  result = ~(a | b);
            OP_SLL:  result = a << b[4:0];
            OP_SRL:  result = a >> b[4:0];
            OP_SLT:  result = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
            OP_ADD: begin
                result   = sum;
                overflow = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
            end
            OP_ADDU: result = sum;
            OP_SUB: begin
                result   = diff;
                overflow = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SUBU: result = diff;
            default: result = '0;
        endcase
    end

    assign zero     = (result == '0);
    assign go_mul   = (state_q == MD_IDLE) && start && (op == OP_MULT);
    assign go_div   = (state_q == MD_IDLE) && start && (op == OP_DIV);
    assign div_zero = (b == '0);

`ifdef ALU_MD_FAST_MULT_EN
    logic [2*WIDTH-1:0] fast_prod;
    assign fast_prod = {{WIDTH{a[WIDTH-1]}}, a} * {{WIDTH{b[WIDTH-1]}}, b};
    assign iter_load = go_div && !div_zero;
`else
    assign iter_load = go_mul || (go_div && !div_zero);
`endif

    alu_md_iter #(.WIDTH(WIDTH)) u_iter (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (iter_load),
        .step     (busy_q),
        .div_mode (state_q == MD_DIV),
        .a        (a),
        .b        (b),
        .last     (iter_last),
        .hi_res   (iter_hi),
        .lo_res   (iter_lo)
    );

    // Mul/div sequencing with registered busy/done; hi/lo load on the edge that enters DONE
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= MD_IDLE;
            hi_q    <= '0;
            lo_q    <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                MD_IDLE: begin
                    if (go_mul) begin
`ifdef ALU_MD_FAST_MULT_EN
                        {hi_q, lo_q} <= fast_prod;
                        done_q       <= 1'b1;
                        state_q      <= MD_DONE;
`else
                        busy_q  <= 1'b1;
                        state_q <= MD_MUL;
`endif
                    end else if (go_div) begin
                        if (div_zero) begin
                            hi_q    <= a;
                            lo_q    <= '1;
                            done_q  <= 1'b1;
                            state_q <= MD_DONE;
                        end else begin
                            busy_q  <= 1'b1;
                            state_q <= MD_DIV;
                        end
                    end
                end
                MD_MUL, MD_DIV: begin
                    if (iter_last) begin
                        hi_q    <= iter_hi;
                        lo_q    <= iter_lo;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= MD_DONE;
                    end
                end
                default: state_q <= MD_IDLE;
            endcase
        end
    end

    assign hi   = hi_q;
    assign lo   = lo_q;
    assign busy = busy_q;
    assign done = done_q;

endmodule

// File: tb/tb_alu_md_unit.sv
// tb/tb_alu_md_unit.sv - self-checking bench for alu_md_unit against an arithmetic reference model
`timescale 1ns/1ps
module tb_alu_md_unit;
    localparam int W = 32;
`ifdef ALU_MD_FAST_MULT_EN
    localparam int MUL_LAT = 1;
`else
    localparam int MUL_LAT = W + 1;
`endif
    localparam int DIV_LAT = W + 1;
    localparam longint SMAX = (64'sd1 <<< (W - 1)) - 64'sd1;
    localparam longint SMIN = -(64'sd1 <<< (W - 1));

    logic         clk = 1'b0;
    logic         rst_n;
    logic [3:0]   alu_operation;
    logic [W-1:0] a, b;
    logic         start;
    logic [W-1:0] result, hi, lo;
    logic         zero, overflow, busy, done;

    int n_cmp = 0;
    int n_bad = 0;

    alu_md_unit #(.WIDTH(W)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .alu_operation (alu_operation),
        .a             (a),
        .b             (b),
        .start         (start),
        .result        (result),
        .zero          (zero),
        .overflow      (overflow),
        .hi            (hi),
        .lo            (lo),
        .busy          (busy),
        .done          (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference ALU: {overflow, result} from signed/unsigned arithmetic on 64-bit values
    function automatic logic [W:0] alu_ref(input logic [3:0] op, input logic [W-1:0] x, input logic [W-1:0] y);
        longint sx, sy, r;
        logic [W-1:0] res;
        logic ov;
        logic [4:0] sh;
        sx  = longint'($signed(x));
        sy  = longint'($signed(y));
        sh  = y[4:0];
        res = '0;
        ov  = 1'b0;
        r   = 0;
        case (op)
            4'd1:  res = x ^ y;
            4'd2:  res = x | y;
            4'd3:  res = x & y;
            4'd4:  res = ~(x | y);
            4'd5:  res = x << sh;
            4'd6:  res = x >> sh;
            4'd7:  res = (sx < sy) ? 1 : 0;
            4'd8:  begin r = sx + sy; res = r[W-1:0]; ov = (r > SMAX) || (r < SMIN); end
            4'd9:  res = x + y;
            4'd10: begin r = sx - sy; res = r[W-1:0]; ov = (r > SMAX) || (r < SMIN); end
            4'd11: res = x - y;
            default: res = '0;
        endcase
        return {ov, res};
    endfunction

    // Reference HI/LO: {hi, lo} for MULT / DIV
    function automatic logic [2*W-1:0] md_ref(input logic [3:0] op, input logic [W-1:0] x, input logic [W-1:0] y);
        longint sx, sy, p, q, rm;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        if (op == 4'd12) begin
            p = sx * sy;
            return p[2*W-1:0];
        end
        if (y == '0) return {x, {W{1'b1}}};
        q  = sx / sy;
        rm = sx % sy;
        return {rm[W-1:0], q[W-1:0]};
    endfunction

    // Model of the HI/LO timing: cycles remaining until done, pending result, done flag
    logic [W-1:0] m_hi = '0, m_lo = '0, p_hi = '0, p_lo = '0;
    logic         m_done = 1'b0;
    int           m_left = 0;

    initial begin : model
        logic was_done;
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                m_hi = '0; m_lo = '0; m_done = 1'b0; m_left = 0;
            end else begin
                was_done = m_done;
                m_done   = 1'b0;
                if (m_left > 0) begin
                    m_left--;
                    if (m_left == 0) begin
                        m_hi = p_hi; m_lo = p_lo; m_done = 1'b1;
                    end
                end else if (!was_done && start && (alu_operation == 4'd12 || alu_operation == 4'd13)) begin
                    {p_hi, p_lo} = md_ref(alu_operation, a, b);
                    if ((alu_operation == 4'd13 && b == '0) || (alu_operation == 4'd12 && MUL_LAT == 1)) begin
                        m_hi = p_hi; m_lo = p_lo; m_done = 1'b1;
                    end else begin
                        m_left = W;
                    end
                end
            end
        end
    end

    // Compare every cycle, mid-way between the input change and the next rising edge
    initial begin : compare
        logic [W-1:0] er;
        logic eo;
        @(posedge clk);
        forever begin
            @(negedge clk);
            #2;
            {eo, er} = alu_ref(alu_operation, a, b);
            check("result", result, er);
            check("zero", zero, er == '0);
            check("overflow", overflow, eo);
            check("busy", busy, m_left > 0);
            check("done", done, m_done);
            check("hi", hi, m_hi);
            check("lo", lo, m_lo);
        end
    end

    task automatic apply(input logic [3:0] op, input logic [W-1:0] x, input logic [W-1:0] y);
        @(negedge clk);
        alu_operation = op; a = x; b = y;
        #3;
    endtask

    task automatic run_md(input string name, input logic [3:0] op, input logic [W-1:0] x,
                          input logic [W-1:0] y, input int exp_lat, input bit hold);
        int  k;
        bit  seen;
        @(negedge clk);
        alu_operation = op; a = x; b = y; start = 1'b1;
        k = 0; seen = 1'b0;
        while (!seen && k < 100) begin
            @(negedge clk);
            k++;
            if (!hold) start = 1'b0;
            #3;
            if (done) seen = 1'b1;
        end
        check(name, seen ? k : -1, exp_lat);
        @(negedge clk);
        start = 1'b0; alu_operation = 4'd0;
    endtask

    task automatic count_dones(input int cycles, output int n);
        n = 0;
        repeat (cycles) begin
            @(negedge clk);
            #3;
            if (done) n++;
        end
    endtask

    logic [3:0]   v_op [0:15] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7,
                                  4'd8, 4'd9, 4'd10, 4'd11, 4'd12, 4'd13, 4'd14, 4'd15};
    logic [W-1:0] v_a [0:15] = '{32'h1234_5678, 32'hF0F0_00FF, 32'h0F00_1234, 32'hFFFF_0000,
                                  32'h0000_00F0, 32'h8000_0001, 32'h8000_0000, 32'h0000_0003,
                                  32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'h0000_0000,
                                  32'h0000_0005, 32'h0000_0009, 32'hDEAD_BEEF, 32'h1111_1111};
    logic [W-1:0] v_b [0:15] = '{32'h1111_1111, 32'h0F0F_FF00, 32'h00F0_0000, 32'h00FF_FF00,
                                  32'h0000_000F, 32'h0000_0021, 32'h0000_001F, 32'hFFFF_FFFE,
                                  32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001, 32'h0000_0001,
                                  32'h0000_0007, 32'h0000_0002, 32'h0000_0001, 32'h2222_2222};

    initial begin : stimulus
        int nd;
        rst_n = 1'b0; start = 1'b0; alu_operation = 4'd0; a = '0; b = '0;
        repeat (2) @(negedge clk);
        #3;
        check("rst_hi", hi, 0);
        check("rst_lo", lo, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Model pins against hand-computed values
        check("model_add", alu_ref(4'd8, 32'h7FFF_FFFF, 32'h1), {1'b1, 32'h8000_0000});
        check("model_sll", alu_ref(4'd5, 32'h1, 32'h24), {1'b0, 32'h10});
        check("model_mult", md_ref(4'd12, -32'sd3, 32'd7), 64'hFFFF_FFFF_FFFF_FFEB);
        check("model_div", md_ref(4'd13, -32'sd7, 32'd2), 64'hFFFF_FFFF_FFFF_FFFD);

        for (int i = 0; i < 16; i++) apply(v_op[i], v_a[i], v_b[i]);

        apply(4'd8, 32'h7FFF_FFFF, 32'h1);
        check("add_result", result, 32'h8000_0000);
        check("add_ovf", overflow, 1);
        apply(4'd9, 32'h7FFF_FFFF, 32'h1);
        check("addu_ovf", overflow, 0);
        apply(4'd10, 32'd5, 32'd5);
        check("sub_result", result, 0);
        check("sub_zero", zero, 1);
        apply(4'd10, 32'h8000_0000, 32'h1);
        check("sub_ovf", overflow, 1);
        apply(4'd7, 32'hFFFF_FFFF, 32'h1);
        check("slt_result", result, 1);
        apply(4'd6, 32'h8000_0000, 32'h1F);
        check("srl_result", result, 1);

        run_md("mult_lat", 4'd12, -32'sd3, 32'd7, MUL_LAT, 1'b0);
        check("mult_hi", hi, 32'hFFFF_FFFF);
        check("mult_lo", lo, 32'hFFFF_FFEB);
        run_md("div_lat", 4'd13, -32'sd7, 32'd2, DIV_LAT, 1'b0);
        check("div_lo", lo, 32'hFFFF_FFFD);
        check("div_hi", hi, 32'hFFFF_FFFF);
        run_md("div0_lat", 4'd13, 32'd9, 32'd0, 1, 1'b1);
        check("div0_hi", hi, 32'd9);
        check("div0_lo", lo, 32'hFFFF_FFFF);
        run_md("div_neg_lat", 4'd13, 32'd7, -32'sd2, DIV_LAT, 1'b1);
        check("div_neg_lo", lo, 32'hFFFF_FFFD);
        check("div_neg_hi", hi, 32'd1);
        run_md("div_min_lat", 4'd13, 32'h8000_0000, 32'hFFFF_FFFF, DIV_LAT, 1'b0);
        check("div_min_lo", lo, 32'h8000_0000);
        check("div_min_hi", hi, 32'd0);
        run_md("mult_min_lat", 4'd12, 32'h8000_0000, 32'h8000_0000, MUL_LAT, 1'b1);
        check("mult_min_hi", hi, 32'h4000_0000);
        check("mult_min_lo", lo, 32'd0);
        run_md("mult_ff_lat", 4'd12, 32'h0001_FFFF, 32'h0000_FFFF, MUL_LAT, 1'b0);

        // A second start while busy is ignored
        @(negedge clk);
        alu_operation = 4'd12; a = 32'd3; b = 32'd4; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        alu_operation = 4'd13; a = 32'd100; b = 32'd7; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        count_dones(60, nd);
        check("busy_start_dones", nd, 1);
        check("busy_start_hi", hi, 32'd0);
        check("busy_start_lo", lo, 32'd12);

        // Reset in the middle of a MULT aborts it
        @(negedge clk);
        alu_operation = 4'd12; a = 32'd5; b = 32'd6; start = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            start = 1'b0;
        end
        rst_n = 1'b0;
        #3;
        check("abort_busy", busy, 0);
        check("abort_hi", hi, 0);
        check("abort_lo", lo, 0);
        @(negedge clk);
        rst_n = 1'b1;
        count_dones(50, nd);
        check("abort_dones", nd, 0);

        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
